wb_write_arbiter: RTL and testbench
===================================

# wb_write_arbiter

Shares the single register-file write port between the in-order pipeline's write-back path and a long-latency unit (multiply/divide) that completes out of band. Pipeline writes always win. Long-latency results wait in a small FIFO and drain into free write slots. A starvation timer forces a pipeline bubble when a queued result has waited too long. The block sits between the WB stage output / long-latency unit and the register file write port.

## Interface
Parameters:
- DATA_W, 32, register data width (matches `WORDLENGTH)
- ADDR_W, 5, register address width
- DEPTH, 2, long-latency result FIFO entries (power of two, ≥2)
- MAX_WAIT, 4, cycles a FIFO head may wait before a bubble is requested

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- pipe_we  in  1  WB stage write enable (RegWrite)
- pipe_addr  in  ADDR_W  WB stage destination register
- pipe_data  in  DATA_W  WB stage write data
- lu_valid  in  1  long-latency result available
- lu_addr  in  ADDR_W  long-latency destination register
- lu_data  in  DATA_W  long-latency result
- lu_ready  out  1  FIFO can accept; push occurs when lu_valid && lu_ready
- rf_we  out  1  register-file write enable (registered)
- rf_addr  out  ADDR_W  register-file write address (registered)
- rf_data  out  DATA_W  register-file write data (registered)
- pipe_hold  out  1  request to hazard unit: next cycle must have pipe_we=0

## Operation
- Effective pipeline write: pipe_we && pipe_addr != 0. Writes to $0 are discarded everywhere, including FIFO pushes with lu_addr == 0, which are accepted and dropped.
- Each cycle, the winner is selected as follows:
  - an effective pipeline write wins;
  - otherwise a valid FIFO head is popped and written;
  - otherwise, with the FIFO empty, an accepted lu push bypasses the FIFO and is written directly.
- Ordering squash: the pipeline is younger than anything queued. On an effective pipeline write, invalidate every queued entry whose addr equals pipe_addr. A concurrent lu push to the same addr is also dropped. Invalidated entries still occupy slots and pop as no-write.
- lu_ready = FIFO count < DEPTH. This is combinational from state only, never from lu_valid.
- Push and pop in the same cycle are legal at any occupancy. Count is unchanged.
- Starvation timer: wait_cnt counts cycles the FIFO is non-empty and the head is not popped. It clears on pop or when the FIFO is empty. When wait_cnt == MAX_WAIT−1, assert pipe_hold for exactly one cycle. Saturate until pop.
- The hazard unit guarantees pipe_we=0 in the cycle after pipe_hold. The head pops in that cycle.

## Timing
- Reset values: rf_we=0, rf_addr=0, rf_data=0, pipe_hold=0, FIFO empty, wait_cnt=0. Consequently lu_ready=1 in the first cycle after reset.
- Latency: an input selected in cycle N appears on rf_* in cycle N+1. FIFO entries add at least one cycle of queueing.
- pipe_hold is registered: raised in the cycle after the threshold is reached, and low for at least one cycle after each pulse.
- Reset mid-operation flushes queued results without writing them. A write already registered on rf_* is cleared to rf_we=0.
- pipe_we with pipe_addr=0 counts as a free slot for draining.

## Configuration
- WB_ARB_STARVE_EN defined: the starvation timer and pipe_hold logic are present as described.
- Undefined: no timer is built, and pipe_hold is tied to 0. FIFO entries drain only in natural free slots.

## Structure
- Shared package (the codebase's common defines/package):
  - the FIFO entry type {valid, addr, data};
  - the zero-register constant;
  - DATA_W/ADDR_W defaults tied to `WORDLENGTH.
- One sub-module: wb_result_fifo. It is a DEPTH-entry circular buffer with push, pop, count/full/empty, and per-entry address-match invalidate. The arbiter holds selection, bypass, squash, and the timer.

## Test plan
- Reset, then pipe_we=1, addr=5, data=0xA5 in cycle 1 → rf_we=1, addr=5, data=0xA5 in cycle 2; lu_ready=1 throughout.
- lu_valid for addr=7, data=0x11 while the pipeline is idle and the FIFO is empty → bypass, rf write of 7/0x11 next cycle, count stays 0.
- pipe_we every cycle while lu pushes addr 8 then 9 → lu_ready=0 after 2 pushes; pipe_hold pulses MAX_WAIT cycles after the first push (macro on). Drop pipe_we for the cycle after the hold → rf writes 8, then 9 when the next gap appears.
- Queue addr=3 data=0x1 behind pipeline traffic, then pipe write addr=3 data=0x2 → final register write is 0x2, and the squashed entry pops with rf_we=0.
- lu push with lu_addr=0, and pipe_we with pipe_addr=0 → no rf_we; the FIFO head drains in the pipe_addr=0 cycle.
- Assert reset with 2 entries queued → next cycle rf_we=0, lu_ready=1, pipe_hold=0, and the entries are never written.

Source files
------------

// File: rtl/wb_write_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Build option: WB_ARB_STARVE_EN enables the starvation timer / pipe_hold.
`ifndef WORDLENGTH
`define WORDLENGTH 32
`endif

package wb_write_arbiter_pkg;

  localparam int DATA_W_DEF = `WORDLENGTH;
  localparam int ADDR_W_DEF = 5;

  // Register $0 is hardwired; writes to it are discarded.
  localparam logic [ADDR_W_DEF-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/wb_write_arbiter_if.sv
// Bus bundle between WB stage / long-latency unit and the register-file write port.
// The arbiter takes the slave modport; the driving side takes master.
interface wb_write_arbiter_if
  import wb_write_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_addr;
  logic [DATA_W-1:0] pipe_data;
  logic              lu_valid;
  logic [ADDR_W-1:0] lu_addr;
  logic [DATA_W-1:0] lu_data;
  logic              lu_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              pipe_hold;

  modport slave (
    input  pipe_we, pipe_addr, pipe_data, lu_valid, lu_addr, lu_data,
    output lu_ready, rf_we, rf_addr, rf_data, pipe_hold
  );

  modport master (
    output pipe_we, pipe_addr, pipe_data, lu_valid, lu_addr, lu_data,
    input  lu_ready, rf_we, rf_addr, rf_data, pipe_hold
  );

endinterface

// File: rtl/wb_result_fifo.sv
// Circular buffer of long-latency results with per-entry address-match invalidate.
// Invalidated entries keep their slot and pop with head_valid=0.
module wb_result_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              inv_en,
  input  logic [ADDR_W-1:0] inv_addr,
  output logic              head_valid,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0]  ent_valid;
  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign head_valid = ent_valid[rd_ptr] && !empty;
  assign head_addr  = ent_addr[rd_ptr];
  assign head_data  = ent_data[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (inv_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_addr[i] == inv_addr) ent_valid[i] <= 1'b0;
        end
      end
      // A push into a slot also matched by the invalidate must win.
      if (push) begin
        ent_valid[wr_ptr] <= 1'b1;
        ent_addr[wr_ptr]  <= push_addr;
        ent_data[wr_ptr]  <= push_data;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline writes win, long-latency results queue and drain.
// Build option: WB_ARB_STARVE_EN adds the starvation timer driving pipe_hold.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  wb_write_arbiter_if.slave  bus
);

  if (DEPTH < 2 || MAX_WAIT < 1) begin : g_bad_cfg
    $error("wb_write_arbiter: DEPTH must be >= 2 and MAX_WAIT >= 1");
  end

  logic              pipe_eff;
  logic              push_acc;
  logic              push_keep;
  logic              head_pop;
  logic              bypass;
  logic              fifo_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic              head_valid;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  assign pipe_eff  = bus.pipe_we && (bus.pipe_addr != ADDR_W'(REG_ZERO));
  assign push_acc  = bus.lu_valid && !fifo_full;
  // The pipeline write is younger, so a same-address lu result is already stale.
  assign push_keep = push_acc && (bus.lu_addr != ADDR_W'(REG_ZERO))
                     && !(pipe_eff && (bus.lu_addr == bus.pipe_addr));
  assign head_pop  = !pipe_eff && !fifo_empty;
  assign bypass    = !pipe_eff && fifo_empty && push_keep;
  assign fifo_push = push_keep && !bypass;

  assign bus.lu_ready = !fifo_full;

  wb_result_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_addr  (bus.lu_addr),
    .push_data  (bus.lu_data),
    .pop        (head_pop),
    .inv_en     (pipe_eff),
    .inv_addr   (bus.pipe_addr),
    .head_valid (head_valid),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = bus.pipe_addr;
    sel_data = bus.pipe_data;
    if (pipe_eff) begin
      sel_we = 1'b1;
    end else if (head_pop) begin
      sel_we   = head_valid;
      sel_addr = head_addr;
      sel_data = head_data;
    end else if (bypass) begin
      sel_we   = 1'b1;
      sel_addr = bus.lu_addr;
      sel_data = bus.lu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rf_we   <= 1'b0;
      bus.rf_addr <= '0;
      bus.rf_data <= '0;
    end else begin
      bus.rf_we <= sel_we;
      if (sel_we) begin
        bus.rf_addr <= sel_addr;
        bus.rf_data <= sel_data;
      end
    end
  end

`ifdef WB_ARB_STARVE_EN
  localparam int              WW      = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WW-1:0]   WAIT_TC = WW'(MAX_WAIT - 1);

  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] wait_nxt;
  logic          hold_fired;
  logic          hold_d;
  logic          hold_q;

  always_comb begin
    wait_nxt = wait_cnt;
    if (fifo_empty || head_pop) wait_nxt = '0;
    else if (wait_cnt != WAIT_TC) wait_nxt = wait_cnt + 1'b1;
  end

  // One pulse per head: hold_fired blocks repeats while the count sits saturated.
  assign hold_d = !fifo_empty && !head_pop && (wait_nxt == WAIT_TC) && !hold_fired;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt   <= '0;
      hold_fired <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      wait_cnt   <= wait_nxt;
      hold_q     <= hold_d;
      hold_fired <= (fifo_empty || head_pop) ? 1'b0 : (hold_fired || hold_d);
    end
  end

  assign bus.pipe_hold = hold_q;
`else
  assign bus.pipe_hold = 1'b0;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed-vector bench for wb_write_arbiter with a write scoreboard.
// Honours WB_ARB_STARVE_EN for the expected pipe_hold values.
module tb_wb_write_arbiter;
  import wb_write_arbiter_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

`ifdef WB_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wb_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  wb_write_arbiter #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .DEPTH    (2),
    .MAX_WAIT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    bit            rst;
    bit            pwe;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    bit            lv;
    logic [AW-1:0] la;
    logic [DW-1:0] ld;
    bit            xwe;
    logic [AW-1:0] xa;
    logic [DW-1:0] xd;
    bit            xrdy;
    bit            xhold;
    bit            xrfz;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(bit rst, bit pwe, int pa, int pd, bit lv, int la, int ld,
                              bit xwe, int xa, int xd, bit xrdy, bit xhold, bit xrfz);
    vec_t v;
    v.rst = rst;  v.pwe = pwe; v.pa = AW'(pa); v.pd = DW'(pd);
    v.lv  = lv;   v.la  = AW'(la); v.ld = DW'(ld);
    v.xwe = xwe;  v.xa  = AW'(xa); v.xd = DW'(xd);
    v.xrdy = xrdy; v.xhold = xhold; v.xrfz = xrfz;
    return v;
  endfunction

  function automatic vec_t idle(bit xrdy, bit xrfz);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, xrdy, 0, xrfz);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (bus.rf_we === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0h, expected no write",
                 bus.rf_addr, bus.rf_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.rf_addr !== e.addr || bus.rf_data !== e.data) begin
          n_fail++;
          $display("FAIL rf_write: got addr %0d data %0h, expected addr %0d data %0h",
                   bus.rf_addr, bus.rf_data, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    // basic write, bypass
    vecs.push_back(mk(0, 1,  5, 'hA5,  0, 0, 0,      1,  5, 'hA5,  1, 0, 1));
    vecs.push_back(idle(1, 0));
    vecs.push_back(mk(0, 0,  0, 0,     1, 7, 'h11,   1,  7, 'h11,  1, 0, 0));
    vecs.push_back(idle(1, 0));
    // starvation: continuous pipeline writes, two queued results
    vecs.push_back(mk(0, 1, 20, 'h100, 1, 8, 'h88,   1, 20, 'h100, 1, 0, 0));
    vecs.push_back(mk(0, 1, 21, 'h101, 1, 9, 'h99,   1, 21, 'h101, 1, 0, 0));
    vecs.push_back(mk(0, 1, 22, 'h102, 0, 0, 0,      1, 22, 'h102, 0, 0, 0));
    vecs.push_back(mk(0, 1, 23, 'h103, 0, 0, 0,      1, 23, 'h103, 0, 0, 0));
    vecs.push_back(mk(0, 1, 24, 'h104, 0, 0, 0,      1, 24, 'h104, 0, 1, 0));
    vecs.push_back(mk(0, 0,  0, 0,     0, 0, 0,      1,  8, 'h88,  0, 0, 0));
    vecs.push_back(mk(0, 1, 25, 'h105, 0, 0, 0,      1, 25, 'h105, 1, 0, 0));
    vecs.push_back(mk(0, 0,  0, 0,     0, 0, 0,      1,  9, 'h99,  1, 0, 0));
    vecs.push_back(idle(1, 0));
    // squash of a queued entry, then of a concurrent push
    vecs.push_back(mk(0, 1, 10, 'h200, 1, 3, 'h1,    1, 10, 'h200, 1, 0, 0));
    vecs.push_back(mk(0, 1,  3, 'h2,   0, 0, 0,      1,  3, 'h2,   1, 0, 0));
    vecs.push_back(idle(1, 0));
    vecs.push_back(idle(1, 1));
    vecs.push_back(mk(0, 1,  4, 'h44,  1, 4, 'h45,   1,  4, 'h44,  1, 0, 0));
    vecs.push_back(idle(1, 0));
    // $0 handling
    vecs.push_back(mk(0, 1, 11, 'h300, 1, 0, 'hDEAD, 1, 11, 'h300, 1, 0, 1));
    vecs.push_back(mk(0, 1, 13, 'h301, 1, 12, 'h312, 1, 13, 'h301, 1, 0, 0));
    vecs.push_back(mk(0, 1,  0, 'hBEEF, 0, 0, 0,     1, 12, 'h312, 1, 0, 0));
    vecs.push_back(idle(1, 0));
    vecs.push_back(mk(0, 0,  0, 0,     1, 0, 'h77,   0,  0, 0,     1, 0, 0));
    vecs.push_back(idle(1, 1));
    // reset with two entries queued
    vecs.push_back(mk(0, 1, 14, 'h400, 1, 15, 'h415, 1, 14, 'h400, 1, 0, 0));
    vecs.push_back(mk(0, 1, 16, 'h401, 1, 17, 'h417, 1, 16, 'h401, 1, 0, 0));
    vecs.push_back(mk(1, 0,  0, 0,     0, 0, 0,      0,  0, 0,     0, 0, 0));
    for (int k = 0; k < 7; k++) vecs.push_back(idle(1, 1));

    bus.pipe_we = 1'b0; bus.pipe_addr = '0; bus.pipe_data = '0;
    bus.lu_valid = 1'b0; bus.lu_addr = '0; bus.lu_data = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_rf_we",     bus.rf_we,     0);
    chk("reset_rf_addr",   bus.rf_addr,   0);
    chk("reset_rf_data",   bus.rf_data,   0);
    chk("reset_pipe_hold", bus.pipe_hold, 0);
    chk("reset_lu_ready",  bus.lu_ready,  1);

    for (int i = 0; i < vecs.size(); i++) begin
      reset         = vecs[i].rst;
      bus.pipe_we   = vecs[i].pwe;
      bus.pipe_addr = vecs[i].pa;
      bus.pipe_data = vecs[i].pd;
      bus.lu_valid  = vecs[i].lv;
      bus.lu_addr   = vecs[i].la;
      bus.lu_data   = vecs[i].ld;
      chk($sformatf("lu_ready_c%0d", i + 1), bus.lu_ready, vecs[i].xrdy);
      chk($sformatf("pipe_hold_c%0d", i + 1), bus.pipe_hold, vecs[i].xhold & STARVE_ON);
      if (vecs[i].xrfz) chk($sformatf("rf_we_idle_c%0d", i + 1), bus.rf_we, 0);
      if (vecs[i].xwe) exp_q.push_back('{addr: vecs[i].xa, data: vecs[i].xd});
      @(posedge clk);
      #1;
    end

    reset = 1'b0;
    bus.pipe_we = 1'b0;
    bus.lu_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
